// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BCD_W      = BCD_DIGITS * DIGIT_W;
  localparam int unsigned BCD_MAX    = 9999;
  localparam int unsigned ADJ_THRESH = 5;
  localparam int unsigned ADJ_ADD    = 3;

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] q_c
);

  always_comb begin
    q_c = d_i;
    if (d_i >= DIGIT_W'(ADJ_THRESH)) q_c = d_i + DIGIT_W'(ADJ_ADD);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Define BIN2BCD_SAT_EN to clamp inputs above 9999 to 9999 before conversion.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [BIN_W-1:0]   bin,
  output logic               busy,
  output logic               done,
  output logic               ovf,
  output logic               dvalid,
  output logic [DIGIT_W-1:0] single_digit,
  output logic [DIGIT_W-1:0] ten_digit,
  output logic [DIGIT_W-1:0] hundred_digit,
  output logic [DIGIT_W-1:0] kilo_digit
);

  localparam int unsigned CNT_W = $clog2(BIN_W);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BIN_W-1:0]         sh_q, sh_d;
  logic [BCD_W-1:0]         acc_q, acc_d;
  logic [BCD_W-1:0]         dig_q, dig_d;
  logic                     ovf_pend_q, ovf_pend_d;
  logic                     ovf_q, ovf_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     dvalid_q, dvalid_d;
  logic                     over_c;
  logic [BCD_W-1:0]         adj_c;
  logic [BCD_W+BIN_W-1:0]   shifted_c;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .d_i (acc_q[g*DIGIT_W +: DIGIT_W]),
      .q_c (adj_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  // The left shift drops the carry out of the thousands digit: result is value mod 10000.
  assign shifted_c = {adj_c, sh_q} << 1;
  assign over_c    = 32'(bin) > 32'(BCD_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      acc_q      <= '0;
      dig_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      dig_q      <= dig_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dvalid_q   <= dvalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    dig_d      = dig_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dvalid_d   = dvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_d = bin;
`ifdef BIN2BCD_SAT_EN
          if (over_c) sh_d = BIN_W'(BCD_MAX);
`endif
          ovf_pend_d = over_c;
          acc_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = shifted_c[BCD_W+BIN_W-1 -: BCD_W];
        sh_d  = shifted_c[BIN_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        // Completion folds into the final shift edge; outputs only change here.
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          dig_d    = acc_d;
          ovf_d    = ovf_pend_q;
          done_d   = 1'b1;
          dvalid_d = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign ovf           = ovf_q;
  assign dvalid        = dvalid_q;
  assign kilo_digit    = dig_q[3*DIGIT_W +: DIGIT_W];
  assign hundred_digit = dig_q[2*DIGIT_W +: DIGIT_W];
  assign ten_digit     = dig_q[1*DIGIT_W +: DIGIT_W];
  assign single_digit  = dig_q[0 +: DIGIT_W];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W = 14;
`ifdef BIN2BCD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin = '0;
  logic             busy, done, ovf, dvalid;
  logic [3:0]       single_digit, ten_digit, hundred_digit, kilo_digit;
  logic [15:0]      digs;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .bin           (bin),
    .busy          (busy),
    .done          (done),
    .ovf           (ovf),
    .dvalid        (dvalid),
    .single_digit  (single_digit),
    .ten_digit     (ten_digit),
    .hundred_digit (hundred_digit),
    .kilo_digit    (kilo_digit)
  );

  always #5 clk = ~clk;
  assign digs = {kilo_digit, hundred_digit, ten_digit, single_digit};

  function automatic logic [15:0] model_digits(input int v);
    int r;
    r = (v > 9999) ? (SAT ? 9999 : v % 10000) : v;
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  // Stimulus only: pulse start with v, then wait (bounded) for done.
  task automatic conv(input int v, output int lat, output logic busy_e0);
    start = 1'b1;
    bin   = BIN_W'(v);
    @(posedge clk); #1;
    start   = 1'b0;
    bin     = BIN_W'($urandom);
    busy_e0 = busy;
    lat     = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, ovf, dvalid, digs} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", {busy, done, ovf, dvalid, digs}, 20'h0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, ovf, dvalid, digs} !== 20'h0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h expected %h", {busy, done, ovf, dvalid, digs}, 20'h0);
    end
  endtask

  task automatic test_in_range();
    int   lat;
    logic b0;
    conv(1234, lat, b0);
    n_checks++;
    if (b0 !== 1'b1) begin n_fail++; $display("FAIL in_range_busy: got %b expected 1", b0); end
    n_checks++;
    if (lat != BIN_W) begin n_fail++; $display("FAIL in_range_latency: got %0d expected %0d", lat, BIN_W); end
    n_checks++;
    if (digs !== model_digits(1234)) begin
      n_fail++; $display("FAIL in_range_digits: got %h expected %h", digs, model_digits(1234));
    end
    n_checks++;
    if ({ovf, dvalid, busy} !== 3'b010) begin
      n_fail++; $display("FAIL in_range_flags: got %b expected 010", {ovf, dvalid, busy});
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b expected 0", done); end
  endtask

  task automatic test_boundaries();
    int   vals[4] = '{0, 9999, 1000, 9};
    int   lat;
    logic b0;
    foreach (vals[i]) begin
      conv(vals[i], lat, b0);
      n_checks++;
      if (digs !== model_digits(vals[i]) || ovf !== 1'b0 || lat != BIN_W) begin
        n_fail++;
        $display("FAIL boundary_%0d: got %h ovf=%b lat=%0d expected %h ovf=0 lat=%0d",
                 vals[i], digs, ovf, lat, model_digits(vals[i]), BIN_W);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    int   vals[2] = '{12345, 16383};
    int   lat;
    logic b0;
    foreach (vals[i]) begin
      conv(vals[i], lat, b0);
      n_checks++;
      if (digs !== model_digits(vals[i]) || ovf !== 1'b1) begin
        n_fail++;
        $display("FAIL overflow_%0d: got %h ovf=%b expected %h ovf=1",
                 vals[i], digs, ovf, model_digits(vals[i]));
      end
      @(posedge clk); #1;
    end
    conv(42, lat, b0);
    n_checks++;
    if (digs !== 16'h0042 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL overflow_clear: got %h ovf=%b expected 0042 ovf=0", digs, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    int lat;
    int pulses;
    start = 1'b1;
    bin   = BIN_W'(4321);
    @(posedge clk); #1;
    start  = 1'b0;
    lat    = 0;
    pulses = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin start = 1'b1; bin = BIN_W'(8888); end
      if (lat == 6) start = 1'b0;
    end
    if (done === 1'b1) pulses++;
    n_checks++;
    if (digs !== 16'h4321 || lat != BIN_W) begin
      n_fail++; $display("FAIL start_ignored: got %h lat=%0d expected 4321 lat=%0d", digs, lat, BIN_W);
    end
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL start_ignored_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int   lat;
    int   gap;
    int   hold_bad;
    logic b0;
    conv(4321, lat, b0);
    start    = 1'b1;
    bin      = BIN_W'(56);
    gap      = 0;
    hold_bad = 0;
    @(posedge clk); #1;
    start = 1'b0;
    gap   = 1;
    while (done !== 1'b1 && gap < 40) begin
      if (digs !== 16'h4321) hold_bad++;
      @(posedge clk); #1;
      gap++;
    end
    n_checks++;
    if (gap != BIN_W + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", gap, BIN_W + 1); end
    n_checks++;
    if (hold_bad != 0) begin n_fail++; $display("FAIL b2b_hold: got %0d changed cycles expected 0", hold_bad); end
    n_checks++;
    if (digs !== 16'h0056) begin n_fail++; $display("FAIL b2b_digits: got %h expected 0056", digs); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic b0;
    logic saw_done;
    start = 1'b1;
    bin   = BIN_W'(777);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, ovf, dvalid, digs} !== 20'h0) begin
      n_fail++; $display("FAIL reset_mid_immediate: got %h expected %h", {busy, done, ovf, dvalid, digs}, 20'h0);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    rstn = 1'b1;
    repeat (16) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0 || dvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_no_done: got done_seen=%b dvalid=%b expected 0 0", saw_done, dvalid);
    end
    conv(3141, lat, b0);
    n_checks++;
    if (digs !== 16'h3141 || lat != BIN_W || dvalid !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_recover: got %h lat=%0d dvalid=%b expected 3141 lat=%0d dvalid=1",
                         digs, lat, dvalid, BIN_W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int   v;
    int   lat;
    logic b0;
    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(0, 16383));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      conv(v, lat, b0);
      n_checks++;
      if (digs !== model_digits(v) || ovf !== (v > 9999) || lat != BIN_W) begin
        n_fail++;
        $display("FAIL random_%0d: got %h ovf=%b lat=%0d expected %h ovf=%b lat=%0d",
                 v, digs, ovf, lat, model_digits(v), (v > 9999), BIN_W);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_in_range();
    test_boundaries();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
